// File: rtl/bip_control.sv
// ============================================================================
// bip_control : BIP fetch/decode/execute control unit with start/halt supervisor
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bip_control #(
    parameter int PC_WIDTH      = 11,
    parameter int OPERAND_WIDTH = 11,
    parameter int OPCODE_WIDTH  = 5,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [PC_WIDTH-1:0]      prog_addr,
    input  logic [15:0]              prog_data,
    output logic [OPERAND_WIDTH-1:0] data_addr,
    output logic                     rd_ram,
    output logic                     wr_ram,
    output logic [OPERAND_WIDTH-1:0] operand,
    output logic [1:0]               sel_a,
    output logic                     sel_b,
    output logic                     op,
    output logic                     wr_acc,
    output logic                     halted,
    output logic                     illegal,
    output logic [CNT_WIDTH-1:0]     cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OPC_HLT  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OPC_STO  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OPC_LD   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OPC_LDI  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OPC_ADD  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OPC_ADDI = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OPC_SUB  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OPC_SUBI = OPCODE_WIDTH'(7);

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [15:0]            ir_q, ir_d;
    logic                   illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic                   rd_req, wr_req, acc_req;
    logic [OPCODE_WIDTH-1:0] dec_opc, exe_opc;
    logic [CNT_WIDTH-1:0]   cnt_inc;

    assign dec_opc = prog_data[OPERAND_WIDTH +: OPCODE_WIDTH];
    assign exe_opc = ir_q[OPERAND_WIDTH +: OPCODE_WIDTH];
    assign cnt_inc = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        acc_req   = 1'b0;
        data_addr = '0;
        operand   = '0;
        sel_a     = 2'd0;
        sel_b     = 1'b0;
        op        = 1'b0;
        halted    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                cnt_d   = cnt_inc;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                cnt_d   = cnt_inc;
                // Memory operands are requested early so RAM data arrives in EXEC.
                if (dec_opc == OPC_LD || dec_opc == OPC_ADD || dec_opc == OPC_SUB) begin
                    rd_req    = 1'b1;
                    data_addr = prog_data[OPERAND_WIDTH-1:0];
                end
                ir_d    = prog_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                cnt_d     = cnt_inc;
                data_addr = ir_q[OPERAND_WIDTH-1:0];
                operand   = ir_q[OPERAND_WIDTH-1:0];
                state_d   = S_FETCH;
                pc_d      = pc_q + PC_WIDTH'(1);
                case (exe_opc)
                    OPC_HLT: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                    OPC_STO:  wr_req = 1'b1;
                    OPC_LD: begin
                        sel_a   = 2'd0;
                        acc_req = 1'b1;
                    end
                    OPC_LDI: begin
                        sel_a   = 2'd1;
                        acc_req = 1'b1;
                    end
                    OPC_ADD: begin
                        sel_a   = 2'd2;
                        acc_req = 1'b1;
                    end
                    OPC_ADDI: begin
                        sel_a   = 2'd2;
                        sel_b   = 1'b1;
                        acc_req = 1'b1;
                    end
                    OPC_SUB: begin
                        sel_a   = 2'd2;
                        op      = 1'b1;
                        acc_req = 1'b1;
                    end
                    OPC_SUBI: begin
                        sel_a   = 2'd2;
                        sel_b   = 1'b1;
                        op      = 1'b1;
                        acc_req = 1'b1;
                    end
                    default: illegal_d = 1'b1;
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) begin
                    state_d   = S_FETCH;
                    pc_d      = '0;
                    cnt_d     = '0;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are masked by reset directly so a reset mid-EXEC cannot corrupt RAM/ACC.
    assign rd_ram    = rd_req  & rst_n;
    assign wr_ram    = wr_req  & rst_n;
    assign wr_acc    = acc_req & rst_n;
    assign prog_addr = pc_q;
    assign illegal   = illegal_q;
    assign cycle_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_bip_control.sv
// ============================================================================
// tb_bip_control : randomized + directed bench for bip_control against a model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_bip_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [10:0] prog_addr;
    logic [15:0] prog_data;
    logic [10:0] data_addr;
    logic        rd_ram, wr_ram;
    logic [10:0] operand;
    logic [1:0]  sel_a;
    logic        sel_b, op, wr_acc, halted, illegal;
    logic [15:0] cycle_cnt;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;

    logic [15:0] rom [0:2047];

    always #5 clk = ~clk;

    bip_control dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .data_addr(data_addr), .rd_ram(rd_ram), .wr_ram(wr_ram),
        .operand(operand), .sel_a(sel_a), .sel_b(sel_b), .op(op),
        .wr_acc(wr_acc), .halted(halted), .illegal(illegal),
        .cycle_cnt(cycle_cnt)
    );

    always @(posedge clk) prog_data <= rom[prog_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Instruction-level reference: run flag, pc, position within the 3-cycle slot.
    bit          m_run = 0, m_halt = 0, m_ill = 0;
    int          m_slot = 0;
    int          m_pc = 0;
    logic [15:0] m_ir = '0;
    int          m_cnt = 0;

    logic [10:0] e_da, e_opnd;
    logic [1:0]  e_sa;
    logic        e_sb, e_op, e_wa, e_rd, e_wr;
    logic [15:0] w;
    logic [63:0] e_vec, a_vec;

    always @(negedge clk) begin
        e_da = '0; e_opnd = '0; e_sa = '0; e_sb = 0; e_op = 0; e_wa = 0; e_rd = 0; e_wr = 0;
        if (m_run && m_slot == 1) begin
            w = rom[m_pc];
            if (w[15:11] == 5'd2 || w[15:11] == 5'd4 || w[15:11] == 5'd6) begin
                e_rd = 1; e_da = w[10:0];
            end
        end
        if (m_run && m_slot == 2) begin
            e_da = m_ir[10:0]; e_opnd = m_ir[10:0];
            case (m_ir[15:11])
                5'd1: e_wr = 1;
                5'd2: begin e_sa = 0; e_wa = 1; end
                5'd3: begin e_sa = 1; e_wa = 1; end
                5'd4: begin e_sa = 2; e_wa = 1; end
                5'd5: begin e_sa = 2; e_sb = 1; e_wa = 1; end
                5'd6: begin e_sa = 2; e_op = 1; e_wa = 1; end
                5'd7: begin e_sa = 2; e_sb = 1; e_op = 1; e_wa = 1; end
                default: ;
            endcase
        end
        if (!rst_n) begin e_rd = 0; e_wr = 0; e_wa = 0; end
        e_vec = {6'd0, 11'(m_pc), e_da, e_opnd, e_sa, e_sb, e_op, e_wa, e_rd, e_wr,
                 m_halt, m_ill, 16'(m_cnt)};
        a_vec = {6'd0, prog_addr, data_addr, operand, sel_a, sel_b, op, wr_acc, rd_ram, wr_ram,
                 halted, illegal, cycle_cnt};
        if (chk_on) chk("outputs", a_vec, e_vec);

        if (!rst_n) begin
            m_run = 0; m_halt = 0; m_ill = 0; m_slot = 0; m_pc = 0; m_ir = '0; m_cnt = 0;
        end else if (!m_run) begin
            if (start) begin
                if (m_halt) m_ill = 0;
                m_run = 1; m_halt = 0; m_slot = 0; m_pc = 0; m_cnt = 0;
            end
        end else begin
            if (m_cnt < 65535) m_cnt++;
            if (m_slot == 0) m_slot = 1;
            else if (m_slot == 1) begin m_ir = rom[m_pc]; m_slot = 2; end
            else if (m_ir[15:11] == 5'd0) begin m_run = 0; m_halt = 1; m_slot = 0; end
            else begin
                if (m_ir[15:11] > 5'd7) m_ill = 1;
                m_pc = (m_pc + 1) % 2048;
                m_slot = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic nneg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        step(); start = 1'b1;
        step(); start = 1'b0;
    endtask

    initial begin
        int len;
        logic [4:0] opc;
        logic [10:0] arg;
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
        step();
        chk_on = 1'b1;
        step(); step();
        rst_n = 1'b1;
        nneg(1);
        chk("reset_state", {halted, illegal, prog_addr, cycle_cnt}, {1'b0, 1'b0, 11'd0, 16'd0});

        // LDI 5; ADDI -2; STO 10; HLT
        rom[0] = 16'h1805; rom[1] = 16'h2FFE; rom[2] = 16'h080A; rom[3] = 16'h0000;
        pulse_start();
        nneg(1); chk("fetch0_addr", prog_addr, 0);
        nneg(1); chk("decode0_addr", prog_addr, 0);
        nneg(1); chk("exec_ldi", {prog_addr, wr_acc, sel_a, operand}, {11'd0, 1'b1, 2'd1, 11'h005});
        nneg(1); chk("fetch1_pc_cnt", {prog_addr, cycle_cnt}, {11'd1, 16'd3});
        nneg(2); chk("exec_addi", {wr_acc, sel_a, sel_b, op, operand}, {1'b1, 2'd2, 1'b1, 1'b0, 11'h7FE});
        nneg(3); chk("exec_sto", {wr_ram, wr_acc, data_addr}, {1'b1, 1'b0, 11'd10});
        nneg(4); chk("halt_state", {halted, prog_addr, cycle_cnt}, {1'b1, 11'd3, 16'd12});

        // LD 7; SUB 8; HLT
        rom[0] = 16'h1007; rom[1] = 16'h3008; rom[2] = 16'h0000;
        pulse_start();
        nneg(2); chk("decode_ld", {rd_ram, data_addr}, {1'b1, 11'd7});
        nneg(1); chk("exec_ld", {rd_ram, sel_a, wr_acc}, {1'b0, 2'd0, 1'b1});
        nneg(2); chk("decode_sub", {rd_ram, data_addr}, {1'b1, 11'd8});
        nneg(1); chk("exec_sub", {sel_a, sel_b, op, wr_acc}, {2'd2, 1'b0, 1'b1, 1'b1});
        nneg(4); chk("halt2", halted, 1);

        // Undefined opcode 11111 then HLT
        rom[0] = 16'hF800; rom[1] = 16'h0000;
        pulse_start();
        nneg(3); chk("illegal_nop", {wr_acc, wr_ram, rd_ram}, 3'b000);
        nneg(1); chk("illegal_flag_pc", {illegal, prog_addr}, {1'b1, 11'd1});
        nneg(3); chk("illegal_halt", {halted, illegal}, 2'b11);
        pulse_start();
        nneg(1); chk("illegal_cleared", {illegal, cycle_cnt}, {1'b0, 16'd0});
        nneg(6);

        // Reset during EXEC of STO, with start held high
        rom[0] = 16'h080A; rom[1] = 16'h0000;
        pulse_start();
        step(); step();
        rst_n = 1'b0; start = 1'b1;
        nneg(1); chk("reset_exec_wr", {wr_ram, data_addr}, {1'b0, 11'd10});
        step();
        nneg(1); chk("reset_to_idle", {halted, prog_addr, cycle_cnt}, {1'b0, 11'd0, 16'd0});
        step(); step();
        rst_n = 1'b1; start = 1'b0;
        nneg(3); chk("idle_after_reset", {halted, prog_addr, cycle_cnt}, {1'b0, 11'd0, 16'd0});

        // PC wrap with ROM full of ADDI 1
        for (int i = 0; i < 2048; i++) rom[i] = 16'h2801;
        pulse_start();
        nneg(6142); chk("pc_top", prog_addr, 11'd2047);
        nneg(3); chk("pc_wrap", {halted, prog_addr, cycle_cnt}, {1'b0, 11'd0, 16'd6144});

        // Randomized programs with stray start pulses and occasional resets
        for (int p = 0; p < 30; p++) begin
            step(); rst_n = 1'b0; start = 1'($urandom_range(0, 1));
            step();
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                opc = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(8, 31))
                                                  : 5'($urandom_range(1, 7));
                arg = 11'($urandom);
                rom[i] = {opc, arg};
            end
            rom[len] = 16'h0000;
            step(); rst_n = 1'b1; start = 1'b1;
            step(); start = 1'b0;
            repeat (3 * len + 12) begin
                step();
                start = ($urandom_range(0, 4) == 0);
                rst_n = ($urandom_range(0, 149) != 0);
            end
        end

        nneg(1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
